// File: rtl/aixh_mxc_pkg.sv
// aixh_mxc_pkg: shared MxConv sizes, left queue-tile state type and helpers
package aixh_mxc_pkg;
  localparam int IPTILE_YCELLS = 4;
  localparam int LPCELL_FWI_DWIDTH = 64;
  localparam int LPCELL_BWO_DWIDTH = 32;
  localparam int LQT_RF_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} lqt_state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aixh_mxc_left_qtile_rfifo.sv
// aixh_mxc_left_qtile_rfifo: per-row result FIFO; a push on full is dropped and flagged unless a pop frees the slot
module aixh_mxc_left_qtile_rfifo #(
  parameter int DW = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          ovf
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full, do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    ovf = push & !do_push;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    wr_q <= rst ? '0 : wr_d;
    rd_q <= rst ? '0 : rd_d;
    cnt_q <= rst ? '0 : cnt_d;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/aixh_mxc_left_qtile.sv
// aixh_mxc_left_qtile: skewed forward feed plus round-robin drain of per-row results.
// AIXH_MXC_LQT_SKEW_EN enables the diagonal skew chains and the DRAIN state.
module aixh_mxc_left_qtile
  import aixh_mxc_pkg::*;
#(
  parameter int YCELLS = IPTILE_YCELLS,
  parameter int FWI_DW = LPCELL_FWI_DWIDTH,
  parameter int BWO_DW = LPCELL_BWO_DWIDTH,
  parameter int RF_DEPTH = LQT_RF_DEPTH,
  localparam int RW = clog2_min1(YCELLS)
) (
  input  logic                     aixh_core_clk2x,
  input  logic                     aixh_core_rst2x,
  input  logic                     i_fwd_vld,
  output logic                     o_fwd_rdy,
  input  logic                     i_fwd_last,
  input  logic [YCELLS*FWI_DW-1:0] i_fwd_dat,
  output logic [YCELLS*FWI_DW-1:0] o_lqt_dat,
  input  logic [YCELLS-1:0]        i_lqt_vld,
  input  logic [YCELLS*BWO_DW-1:0] i_lqt_dat,
  output logic                     o_res_vld,
  input  logic                     i_res_rdy,
  output logic [RW-1:0]            o_res_row,
  output logic [BWO_DW-1:0]        o_res_dat,
  output logic [YCELLS-1:0]        o_ovf,
  input  logic                     i_ovf_clr,
  output logic                     o_busy
);
`ifdef AIXH_MXC_LQT_SKEW_EN
  localparam bit USE_DRAIN = YCELLS > 1;
`else
  localparam bit USE_DRAIN = 1'b0;
`endif
  localparam int CW = clog2_min1(YCELLS);
  logic clk, rst;
  assign clk = aixh_core_clk2x;
  assign rst = aixh_core_rst2x;
  lqt_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc;
  logic [YCELLS*FWI_DW-1:0] fwd_d;
  assign o_fwd_rdy = !rst && state_q != DRAIN;
  assign acc = i_fwd_vld & o_fwd_rdy;
  assign fwd_d = acc ? i_fwd_dat : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == DRAIN) begin
      state_d = (cnt_q == '0) ? IDLE : DRAIN;
      cnt_d = cnt_q - CW'(1);
    end else if (acc) begin
      state_d = !i_fwd_last ? STREAM : (USE_DRAIN ? DRAIN : IDLE);
      cnt_d = CW'(USE_DRAIN ? YCELLS - 2 : 0);
    end
  end
`ifdef AIXH_MXC_LQT_SKEW_EN
  for (genvar y = 0; y < YCELLS; y++) begin : g_skew
    logic [FWI_DW-1:0] sk_q [0:y];
    always_ff @(posedge clk)
      if (rst) begin
        for (int k = 0; k <= y; k++) sk_q[k] <= '0;
      end else begin
        sk_q[0] <= fwd_d[y*FWI_DW+:FWI_DW];
        for (int k = 1; k <= y; k++) sk_q[k] <= sk_q[k-1];
      end
    assign o_lqt_dat[y*FWI_DW+:FWI_DW] = sk_q[y];
  end
`else
  logic [YCELLS*FWI_DW-1:0] lqt_q;
  always_ff @(posedge clk) lqt_q <= rst ? '0 : fwd_d;
  assign o_lqt_dat = lqt_q;
`endif
  logic [YCELLS-1:0] f_empty, f_ovf, f_pop;
  logic [BWO_DW-1:0] f_dout [YCELLS];
  for (genvar y = 0; y < YCELLS; y++) begin : g_rf
    aixh_mxc_left_qtile_rfifo #(.DW(BWO_DW), .DEPTH(RF_DEPTH)) u_rf (
      .clk   (clk),
      .rst   (rst),
      .push  (i_lqt_vld[y]),
      .pop   (f_pop[y]),
      .din   (i_lqt_dat[y*BWO_DW+:BWO_DW]),
      .dout  (f_dout[y]),
      .empty (f_empty[y]),
      .ovf   (f_ovf[y])
    );
  end
  logic [RW-1:0] rr_q, rr_d, sel_q, sel_d, pick;
  logic lock_q, lock_d, hs;
  logic [YCELLS-1:0] ovf_q, ovf_d;
  always_comb begin
    pick = rr_q;
    for (int i = YCELLS - 1; i >= 0; i--)
      if (!f_empty[(int'(rr_q) + i) % YCELLS]) pick = RW'((int'(rr_q) + i) % YCELLS);
    // a stalled offer stays pinned to its row even if a preferred row fills meanwhile
    sel_d = lock_q ? sel_q : pick;
    o_res_vld = !(&f_empty);
    hs = o_res_vld & i_res_rdy;
    lock_d = o_res_vld & !i_res_rdy;
    rr_d = hs ? ((sel_d == RW'(YCELLS - 1)) ? '0 : sel_d + RW'(1)) : rr_q;
    f_pop = hs ? (YCELLS'(1) << sel_d) : '0;
    ovf_d = (ovf_q & ~{YCELLS{i_ovf_clr}}) | f_ovf;
  end
  assign o_res_row = sel_d;
  assign o_res_dat = f_dout[sel_d];
  assign o_ovf = ovf_q;
  assign o_busy = state_q != IDLE || o_res_vld;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_q <= '0;
      sel_q <= '0;
      lock_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      sel_q <= sel_d;
      lock_q <= lock_d;
      ovf_q <= ovf_d;
    end
endmodule
